// File: rtl/quadrature_decoder_pkg.sv
// rtl/quadrature_decoder_pkg.sv - shared constants, state enum and Gray helper for the quadrature decoder
package quadrature_decoder_pkg;

  // Clockwise Gray sequence of the {A,B} pair
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  // Position deltas; the paddle logic compares its difference against these
  localparam logic [1:0] STEP_POS = 2'b01;
  localparam logic [1:0] STEP_NEG = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Next {A,B} pair one clockwise detent after s
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      GRAY_S0: n = GRAY_S1;
      GRAY_S1: n = GRAY_S2;
      GRAY_S2: n = GRAY_S3;
      default: n = GRAY_S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quadrature_decoder_debounce_sync.sv
// rtl/quadrature_decoder_debounce_sync.sv - synchroniser plus debouncer for one raw encoder pin
module quadrature_decoder_debounce_sync
  import quadrature_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic load,
  output logic sync,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Metastability chain; only its last stage is used downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles; load forces it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      level <= sync;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - debounced quadrature encoder to 2-bit wrapping position with step pulses
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] encoder_value,
  output logic       step_cw,
  output logic       step_ccw,
  output logic       error
);

  localparam int INIT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic [1:0]        prev_ab;
  logic              sync_a, sync_b;
  logic              deb_a, deb_b;
  logic              load;
  logic [1:0]        sync_ab, deb_ab;

  assign sync_ab = {sync_a, sync_b};
  assign deb_ab  = {deb_a, deb_b};
  // Once the sync chains hold real pin levels, seed the debouncers so a non-00 rest detent is not counted
  assign load    = (state == ST_INIT) && (init_cnt == INIT_LAST);

  quadrature_decoder_debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .pin  (enc_a),
    .load (load),
    .sync (sync_a),
    .level(deb_a)
  );

  quadrature_decoder_debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .pin  (enc_b),
    .load (load),
    .sync (sync_b),
    .level(deb_b)
  );

  // INIT absorbs the resting pin levels; RUN classifies each debounced pair change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_INIT;
      init_cnt      <= '0;
      prev_ab       <= GRAY_S0;
      encoder_value <= 2'b00;
      step_cw       <= 1'b0;
      step_ccw      <= 1'b0;
      error         <= 1'b0;
    end else begin
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      error    <= 1'b0;
      case (state)
        ST_INIT: begin
          if (load) begin
            prev_ab <= sync_ab;
            state   <= ST_RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (deb_ab != prev_ab) begin
            prev_ab <= deb_ab;
            if (deb_ab == cw_next(prev_ab)) begin
              encoder_value <= encoder_value + STEP_POS;
              step_cw       <= 1'b1;
            end else if (prev_ab == cw_next(deb_ab)) begin
              encoder_value <= encoder_value + STEP_NEG;
              step_ccw      <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - scoreboard bench for quadrature_decoder
module tb_quadrature_decoder;

  localparam int LAT    = 2 + 16 + 1;
  localparam int K_NONE = 0;
  localparam int K_CW   = 1;
  localparam int K_CCW  = 2;
  localparam int K_ERR  = 3;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] encoder_value;
  logic       step_cw;
  logic       step_ccw;
  logic       error;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  n_cw     = 0;
  int  n_ccw    = 0;
  int  n_err    = 0;

  quadrature_decoder #(
    .DEBOUNCE_CYCLES(16),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .encoder_value(encoder_value),
    .step_cw      (step_cw),
    .step_ccw     (step_ccw),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Set pins at a falling edge, queue the event they should cause, then hold them
  task automatic drive(input logic a, input logic b, input int kind, input int val, input int hold);
    ev_t e;
    if (kind != K_NONE) begin
      e.kind  = kind;
      e.value = val;
      e.cyc   = cyc + LAT;
      exp_q.push_back(e);
    end
    enc_a = a;
    enc_b = b;
    repeat (hold) @(negedge clk);
  endtask

  // Every pulse must match the head of the scoreboard in kind, value and timing
  always @(negedge clk) begin
    if (step_cw || step_ccw || error) begin
      int   kind;
      ev_t  e;
      kind = step_cw ? K_CW : (step_ccw ? K_CCW : K_ERR);
      if (step_cw)  n_cw++;
      if (step_ccw) n_ccw++;
      if (error)    n_err++;
      check("exclusive", int'(step_cw) + int'(step_ccw) + int'(error), 1);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", kind, K_NONE);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_value", int'(encoder_value), e.value);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    #2;
    check("rst_value", int'(encoder_value), 0);
    check("rst_cw", int'(step_cw), 0);
    check("rst_ccw", int'(step_ccw), 0);
    check("rst_err", int'(error), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("idle11_value", int'(encoder_value), 0);

    // Restart resting at 00
    reset = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("idle00_value", int'(encoder_value), 0);

    // Clockwise: 00->01->11->10->00
    drive(1'b0, 1'b1, K_CW, 1, 40);
    drive(1'b1, 1'b1, K_CW, 2, 40);
    drive(1'b1, 1'b0, K_CW, 3, 40);
    drive(1'b0, 1'b0, K_CW, 0, 40);
    check("cw_value", int'(encoder_value), 0);
    check("cw_count", n_cw, 4);

    // Counter-clockwise from 00: 10, 11, 01
    drive(1'b1, 1'b0, K_CCW, 3, 40);
    drive(1'b1, 1'b1, K_CCW, 2, 40);
    drive(1'b0, 1'b1, K_CCW, 1, 40);
    check("ccw_value", int'(encoder_value), 1);
    check("ccw_count", n_ccw, 3);
    check("ccw_no_cw", n_cw, 4);

    // Glitches on A of 10 and 15 cycles are rejected, a sustained level is one CW step
    drive(1'b1, 1'b1, K_NONE, 0, 10);
    drive(1'b0, 1'b1, K_NONE, 0, 30);
    drive(1'b1, 1'b1, K_NONE, 0, 15);
    drive(1'b0, 1'b1, K_NONE, 0, 30);
    check("glitch_value", int'(encoder_value), 1);
    check("glitch_cw", n_cw, 4);
    drive(1'b1, 1'b1, K_CW, 2, 40);
    check("hold_value", int'(encoder_value), 2);

    // Walk back to 00, then a double-bit jump 00->11, then 11->10
    drive(1'b1, 1'b0, K_CW, 3, 40);
    drive(1'b0, 1'b0, K_CW, 0, 40);
    drive(1'b1, 1'b1, K_ERR, 0, 40);
    check("err_value", int'(encoder_value), 0);
    check("err_count", n_err, 1);
    drive(1'b1, 1'b0, K_CW, 1, 40);
    check("after_err_value", int'(encoder_value), 1);

    // Reset part way through debouncing 10->11
    drive(1'b1, 1'b1, K_NONE, 0, 10);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_value", int'(encoder_value), 0);
    check("midrst_cw", int'(step_cw), 0);
    check("midrst_ccw", int'(step_ccw), 0);
    check("midrst_err", int'(error), 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("postrst_value", int'(encoder_value), 0);

    check("total_cw", n_cw, 8);
    check("total_ccw", n_ccw, 3);
    check("total_err", n_err, 1);
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Front end for the rotary-encoder paddle controls. Takes the raw, asynchronous A/B pins of a mechanical quadrature encoder, then synchronises and debounces them.
- Decodes each valid Gray-code transition into a 2-bit wrapping signed position that the paddle logic differentiates: +1 (01) moves one way, −1 (11) the other.
- Also emits single-cycle direction pulses and an illegal-transition flag for debug/LED use.
- One instance per player.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised pin must hold a new level before it is accepted (≥1).
- SYNC_STAGES, 2, flip-flop stages on each raw pin (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enc_a  input  1  raw encoder channel A, asynchronous to clk
- enc_b  input  1  raw encoder channel B, asynchronous to clk
- encoder_value  output  2  signed position, modulo 4, changes by at most ±1 per cycle
- step_cw  output  1  one-cycle pulse on each +1 step
- step_ccw  output  1  one-cycle pulse on each −1 step
- error  output  1  one-cycle pulse on an illegal (double-bit) transition

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release by clk edge):
  - encoder_value=00; step_cw=step_ccw=error=0.
  - Sync chains, debounce counters and debounced state all cleared.
  - FSM enters INIT.
- Synchroniser: SYNC_STAGES flops per pin. Nothing downstream samples a raw pin.
- Debouncer, independent per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised level equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1 and the level still differs, the debounced level flips on the next edge and the counter clears.
  - Any glitch back to the debounced level clears the counter.
- FSM state INIT:
  - Waits SYNC_STAGES cycles after reset release.
  - Then loads both debounced levels directly from the synchronised pins, with no step and no error, and moves to RUN.
  - This prevents a spurious count when the encoder rests at a non-00 detent.
- FSM state RUN: compares the previous debounced pair {A,B} with the current pair each cycle.
  - CW sequence 00→01→11→10→00: encoder_value +1 (wraps 11→00); step_cw=1 for one cycle.
  - CCW sequence (reverse): encoder_value −1 (wraps 00→11); step_ccw=1 for one cycle.
  - No change: hold; all pulses 0.
  - Both bits change in the same cycle: encoder_value holds; error=1 for one cycle; the previous pair updates to the new pair.
- Outputs are registered. Step pulses and the encoder_value update occur on the same edge.
- Latency, clean pin edge to encoder_value change: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- At most one step per cycle. step_cw, step_ccw and error are mutually exclusive.
- Reset mid-operation: everything returns to reset values immediately; INIT is re-run after release.
- Pulses shorter than DEBOUNCE_CYCLES never propagate.

Decomposition:
- Shared package holds:
  - the CW Gray-sequence constants 2'b00/01/11/10;
  - the step encoding STEP_POS=2'b01 and STEP_NEG=2'b11, which the paddle uses as its diff comparisons;
  - FSM state enum INIT/RUN.
- One natural sub-module, debounce_sync: synchroniser plus debouncer for one pin, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. Instantiate it twice.

Test Plan:
- Reset with enc_a=enc_b=1 held, release, wait 100 cycles → encoder_value=00, no step_cw/step_ccw/error pulse ever asserted.
- Four clean CW transitions (00→01→11→10→00), each held 40 cycles, DEBOUNCE_CYCLES=16:
  - encoder_value sequences 01,10,11,00;
  - exactly 4 step_cw pulses;
  - each pulse 2+16+1=19 cycles after the pin edge.
- Three CCW transitions from 00 → encoder_value 11,10,01; 3 step_ccw pulses; step_cw never asserted.
- Glitch: enc_a pulse of 10 cycles, then 15 cycles, with DEBOUNCE_CYCLES=16 → no value change, no pulses. A 16-cycle hold then produces exactly one step.
- Both pins toggled 00→11 on the same clock and held → one error pulse, encoder_value unchanged. A subsequent 11→10 gives a normal +1 step.
- Assert reset mid-debounce, part way through an accepted edge → outputs immediately 00/0. After release, INIT absorbs the current pin levels with no step.
